// File: rtl/msfsm_sync_fsm.sv
// One-hot marked-place FSM that fires the lowest enabled synchronised transition.
// Optional stall detection is built only when MSFSM_STALL_DET_EN is defined.
module msfsm_sync_fsm #(
  parameter int                 NP         = 4,
  parameter int                 NT         = 4,
  parameter int                 NPART      = 2,
  parameter int                 PW         = 4,
  parameter logic [NT*PW-1:0]   PRE        = 16'h2110,
  parameter logic [NT*PW-1:0]   POST       = 16'h0321,
  parameter int                 INIT_PLACE = 0,
  parameter int                 CW         = 16,
  parameter int                 STALL_LIM  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NT-1:0]         t_req_i,
  input  logic [NT*NPART-1:0]   partner_rdy_i,
  output logic [NT-1:0]         t_local_en_o,
  output logic [NP-1:0]         place_o,
  output logic [NT-1:0]         t_fire_o,
  output logic                  conflict_o,
  output logic [CW-1:0]         fire_cnt_o,
  output logic                  stall_o
);

  localparam logic [NP-1:0] InitOh = {{(NP-1){1'b0}}, 1'b1} << INIT_PLACE;

  logic [NT-1:0][NP-1:0] preMask;
  logic [NT-1:0][NP-1:0] postMask;
  logic [NT-1:0]         partnerAll;
  logic [NT-1:0]         postOk;
  logic [NT-1:0]         enabled;
  logic [NT-1:0]         fireVec;
  logic                  anyFire;
  logic                  multiEn;

  logic [NP-1:0] place_q, place_d;
  logic [NT-1:0] tFire_q, tFire_d;
  logic          conflict_q, conflict_d;
  logic [CW-1:0] fireCnt_q, fireCnt_d;

  // Index tables become constant one-hot masks; an out-of-range index yields an empty mask.
  for (genvar gi = 0; gi < NT; gi++) begin : g_trans
    for (genvar gp = 0; gp < NP; gp++) begin : g_place
      assign preMask[gi][gp]  = (PRE[gi*PW +: PW]  == PW'(gp));
      assign postMask[gi][gp] = (POST[gi*PW +: PW] == PW'(gp));
    end
    assign partnerAll[gi]   = &partner_rdy_i[gi*NPART +: NPART];
    assign postOk[gi]       = |postMask[gi];
    assign t_local_en_o[gi] = |(place_q & preMask[gi]);
  end

  assign enabled = t_req_i & t_local_en_o & partnerAll & postOk & {NT{~|tFire_q}};
  assign fireVec = enabled & (~enabled + NT'(1));
  assign anyFire = |enabled;
  assign multiEn = |(enabled & (enabled - NT'(1)));

  always_comb begin
    place_d    = place_q;
    tFire_d    = fireVec;
    conflict_d = multiEn;
    fireCnt_d  = fireCnt_q;
    if (anyFire) begin
      fireCnt_d = fireCnt_q + CW'(1);
      for (int i = 0; i < NT; i++) begin
        if (fireVec[i]) place_d = postMask[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      place_q    <= InitOh;
      tFire_q    <= '0;
      conflict_q <= 1'b0;
      fireCnt_q  <= '0;
    end else begin
      place_q    <= place_d;
      tFire_q    <= tFire_d;
      conflict_q <= conflict_d;
      fireCnt_q  <= fireCnt_d;
    end
  end

  assign place_o    = place_q;
  assign t_fire_o   = tFire_q;
  assign conflict_o = conflict_q;
  assign fire_cnt_o = fireCnt_q;

`ifdef MSFSM_STALL_DET_EN
  localparam int SW = $clog2(STALL_LIM + 1);

  logic [SW-1:0] stallCnt_q, stallCnt_d;
  logic          stall_q, stall_d;
  logic          stallCond;

  // A locally ready, requested transition held back only by a partner counts as stalled.
  assign stallCond = |(t_req_i & t_local_en_o & ~partnerAll);

  always_comb begin
    stallCnt_d = stallCnt_q;
    stall_d    = stall_q;
    if (anyFire) begin
      stallCnt_d = '0;
      stall_d    = 1'b0;
    end else if (stallCond && (stallCnt_q != SW'(STALL_LIM))) begin
      stallCnt_d = stallCnt_q + SW'(1);
      if (stallCnt_d == SW'(STALL_LIM)) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stallCnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      stallCnt_q <= stallCnt_d;
      stall_q    <= stall_d;
    end
  end

  assign stall_o = stall_q;
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: doc/msfsm_sync_fsm.md
MSFSM_SYNC_FSM -- requirements
Module: msfsm_sync_fsm

Interface
REQ-001 Parameter NP, default 4: number of local places, range 2..16.
REQ-002 Parameter NT, default 4: number of transitions visible to this FSM, range 1..16.
REQ-003 Parameter NPART, default 2: partner-FSM ready inputs per transition, range 1..4; unused slots are tied 1.
REQ-004 Parameter PW, default 4: place-index width.
REQ-005 Parameter PRE, default {t3:2, t2:1, t1:1, t0:0}: NT*PW packed pre-place index per transition.
REQ-006 Parameter POST, default {t3:0, t2:3, t1:2, t0:1}: NT*PW packed post-place index per transition.
REQ-007 Parameter INIT_PLACE, default 0: marked place after reset.
REQ-008 Parameter CW, default 16: fire-counter width.
REQ-009 Parameter STALL_LIM, default 8: stall threshold in cycles.
REQ-010 clk  input  1  rising-edge clock.
REQ-011 reset  input  1  asynchronous, active-high reset.
REQ-012 t_req  input  NT  environment firing request per transition; held until t_fire.
REQ-013 partner_rdy  input  NT*NPART  partner state-sync signals, slice i = transition i.
REQ-014 t_local_en  output  NT  state-sync output: 1 when this FSM marks PRE[i].
REQ-015 place  output  NP  one-hot registered marking.
REQ-016 t_fire  output  NT  one-hot, one-cycle pulse for the fired transition.
REQ-017 conflict  output  1  one-cycle pulse: more than one transition was enabled at a fire edge.
REQ-018 fire_cnt  output  CW  total firings since reset.
REQ-019 stall  output  1  sticky stall flag.

Function
REQ-020 t_local_en[i] SHALL be combinational (Mealy) = place[PRE[i]]; 0 if PRE[i] >= NP.
REQ-021 Transition i SHALL be enabled when t_req[i], t_local_en[i] and all NPART partner_rdy bits of slice i are 1, and t_fire is all zero.
REQ-022 On a clock edge with at least one transition enabled, the lowest-index enabled transition k SHALL fire: place <= one-hot POST[k], t_fire <= one-hot k, fire_cnt += 1.
REQ-023 A transition with POST[k] >= NP SHALL never be enabled.
REQ-024 Fire latency SHALL be one cycle: place and t_fire update on the edge that samples the enable.
REQ-025 The cycle after a fire SHALL be a blocked cycle (t_fire nonzero); back-to-back fires are spaced at least 2 cycles apart.
REQ-026 conflict SHALL pulse for one cycle, coincident with t_fire, when two or more transitions were enabled at the fire edge.
REQ-027 With no transition enabled, place, t_fire (to 0) and fire_cnt SHALL hold.
REQ-028 fire_cnt SHALL wrap modulo 2^CW.
REQ-029 A self-loop (PRE[k] == POST[k]) SHALL fire normally, with place unchanged.

Reset
REQ-030 Asserting reset at any time, including mid-handshake, SHALL force:
- place = one-hot INIT_PLACE
- t_fire = 0
- conflict = 0
- fire_cnt = 0
- stall = 0
- the stall counter = 0
REQ-031 After release, the first fire SHALL be possible on the first rising edge with reset low.

Configuration
REQ-032 Macro MSFSM_STALL_DET_EN defined: the stall counter increments each cycle in which some t_req[i] and t_local_en[i] are 1 but a partner_rdy bit of slice i is 0.
REQ-033 With MSFSM_STALL_DET_EN, the stall counter clears on any fire; stall sets when the counter reaches STALL_LIM and clears only on a fire or reset.
REQ-034 Without MSFSM_STALL_DET_EN, stall SHALL be constant 0 and no counter logic exists.

Verification
REQ-035 Reset, then t_req=0001 with partner_rdy all 1 -> next edge: place=0010, t_fire=0001 for one cycle, fire_cnt=1.
REQ-036 In p1 with t_req=0110 and partners ready -> t1 fires, place=0100, conflict=1 for one cycle.
REQ-037 In p0 with t_req=0001 and partner_rdy[1:0] of t0 = 01 -> no fire; with MSFSM_STALL_DET_EN, stall=1 after 8 cycles; raising the partner bit -> fire, stall=0.
REQ-038 Sequence t0,t1,t3 repeated 2^CW/3+1 times with CW=4 -> fire_cnt wraps correctly and place=0001 after each t3.
REQ-039 Assert reset for one cycle, asynchronously, during a t_fire pulse -> all outputs return to reset values immediately, with no fire on the reset edge.
REQ-040 Reach p3, a sink place -> t_local_en=0000, and no fire occurs for any t_req pattern.
